// File: rtl/uart_rx_fifo_if.sv
// Read-side channel of the UART receive FIFO: head word, valid and ready.
// master = FIFO (drives rd_data/rd_valid), slave = consumer (drives rd_ready).
interface uart_rx_fifo_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] rd_data;
    logic                 rd_valid;
    logic                 rd_ready;

    modport master (
        output rd_data,
        output rd_valid,
        input  rd_ready
    );

    modport slave (
        input  rd_data,
        input  rd_valid,
        output rd_ready
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// Receive byte FIFO behind a UART receiver: captures rx_data on each rising
// edge of rx_ready, drains over a first-word-fall-through valid/ready port.
// Ports: sysclk, rst (sync, active-high), rx_data/rx_ready (receiver side),
// rd (head word channel), count/empty/full/almost_full, overrun/clr_overrun.
module uart_rx_fifo #(
    parameter int DATA_BITS = 8,
    parameter int ADDR_BITS = 4,
    parameter int AF_LEVEL  = 12
) (
    input  logic                 sysclk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] rx_data,
    input  logic                 rx_ready,
    uart_rx_fifo_if.master       rd,
    output logic [ADDR_BITS:0]   count,
    output logic                 empty,
    output logic                 full,
    output logic                 almost_full,
    output logic                 overrun,
    input  logic                 clr_overrun
);
    localparam int DEPTH = 1 << ADDR_BITS;
    localparam logic [ADDR_BITS:0] DEPTH_C = (ADDR_BITS + 1)'(DEPTH);
    localparam logic [ADDR_BITS:0] AF_C    = (ADDR_BITS + 1)'(AF_LEVEL);

    logic [DATA_BITS-1:0] mem [DEPTH];
    logic [ADDR_BITS-1:0] wr_ptr;
    logic [ADDR_BITS-1:0] rd_ptr;
    logic                 rdy_q;
    logic                 wr_req;
    logic                 wr_acc;
    logic                 wr_drop;
    logic                 rd_fire;

    // rdy_q resets high so a level already asserted at reset release
    // (or at a mid-stream reset) is treated as already consumed.
    assign wr_req  = rx_ready & ~rdy_q;
    assign rd_fire = rd.rd_valid & rd.rd_ready;
    // A read in the same cycle frees the slot the write needs.
    assign wr_acc  = wr_req & (~full | rd_fire);
    assign wr_drop = wr_req & full & ~rd_fire;

    assign empty       = (count == '0);
    assign full        = (count == DEPTH_C);
    assign almost_full = (count >= AF_C);

    assign rd.rd_valid = ~empty;
    assign rd.rd_data  = mem[rd_ptr];

    always_ff @(posedge sysclk) begin
        if (wr_acc) begin
            mem[wr_ptr] <= rx_data;
        end
    end

    always_ff @(posedge sysclk) begin
        if (rst) begin
            rdy_q   <= 1'b1;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            overrun <= 1'b0;
        end else begin
            rdy_q <= rx_ready;
            if (wr_acc) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_fire) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({wr_acc, rd_fire})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            // Set has priority over clear.
            if (wr_drop) begin
                overrun <= 1'b1;
            end else if (clr_overrun) begin
                overrun <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: scoreboard queue of written words,
// compared against the FIFO head as words are drained.
module tb_uart_rx_fifo;
    logic       sysclk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] rx_data = 8'h00;
    logic       rx_ready = 1'b0;
    logic       clr_overrun = 1'b0;
    logic [4:0] count;
    logic       empty;
    logic       full;
    logic       almost_full;
    logic       overrun;

    int n_pass = 0;
    int n_total = 0;
    logic [7:0] sb [$];

    uart_rx_fifo_if #(.DATA_BITS(8)) rd_if ();

    uart_rx_fifo #(
        .DATA_BITS(8),
        .ADDR_BITS(4),
        .AF_LEVEL(12)
    ) dut (
        .sysclk(sysclk),
        .rst(rst),
        .rx_data(rx_data),
        .rx_ready(rx_ready),
        .rd(rd_if),
        .count(count),
        .empty(empty),
        .full(full),
        .almost_full(almost_full),
        .overrun(overrun),
        .clr_overrun(clr_overrun)
    );

    always #5 sysclk = ~sysclk;

    task automatic step();
        @(posedge sysclk);
        #1;
    endtask

    // Two-cycle write: rising edge captured at the first posedge, then low.
    task automatic push_word(input logic [7:0] d, input bit expect_kept);
        rx_data = d;
        rx_ready = 1'b1;
        step();
        rx_ready = 1'b0;
        if (expect_kept) sb.push_back(d);
        step();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        rx_ready = 1'b1;
        rd_if.rd_ready = 1'b0;
        repeat (3) step();
        rst = 1'b0;
        step();
        n_total++;
        if ({rd_if.rd_valid, empty, full, almost_full, overrun, count} !==
            {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0})
            $display("FAIL reset_state: got v=%b e=%b f=%b af=%b ov=%b cnt=%0d",
                     rd_if.rd_valid, empty, full, almost_full, overrun, count);
        else n_pass++;
        repeat (10) step();
        n_total++;
        if (count !== 5'd0 || rd_if.rd_valid !== 1'b0)
            $display("FAIL held_level: cnt=%0d v=%b, want 0/0",
                     count, rd_if.rd_valid);
        else n_pass++;
        rx_ready = 1'b0;
        step();
        rx_data = 8'hA5;
        rx_ready = 1'b1;
        step();
        sb.push_back(8'hA5);
        n_total++;
        if (count !== 5'd1 || rd_if.rd_valid !== 1'b1 ||
            rd_if.rd_data !== sb[0])
            $display("FAIL first_write: cnt=%0d v=%b d=%h, want 1/1/%h",
                     count, rd_if.rd_valid, rd_if.rd_data, sb[0]);
        else n_pass++;
        rx_ready = 1'b0;
        rd_if.rd_ready = 1'b1;
        step();
        void'(sb.pop_front());
        rd_if.rd_ready = 1'b0;
        n_total++;
        if (empty !== 1'b1)
            $display("FAIL first_drain: empty=%b, want 1", empty);
        else n_pass++;
    endtask

    task automatic test_fill_drain();
        for (int i = 0; i < 16; i++) begin
            rx_data = 8'(i + 1);
            rx_ready = 1'b1;
            step();
            rx_ready = 1'b0;
            sb.push_back(8'(i + 1));
            n_total++;
            if (count !== 5'(i + 1) || almost_full !== (i + 1 >= 12))
                $display("FAIL fill_%0d: cnt=%0d af=%b, want %0d/%b",
                         i + 1, count, almost_full, i + 1, (i + 1 >= 12));
            else n_pass++;
            step();
        end
        n_total++;
        if (full !== 1'b1 || count !== 5'd16)
            $display("FAIL fill_full: full=%b cnt=%0d, want 1/16", full, count);
        else n_pass++;
        rd_if.rd_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            @(negedge sysclk);
            n_total++;
            if (rd_if.rd_valid !== 1'b1 || rd_if.rd_data !== sb[0])
                $display("FAIL drain_%0d: v=%b d=%h, want 1/%h",
                         i, rd_if.rd_valid, rd_if.rd_data, sb[0]);
            else n_pass++;
            void'(sb.pop_front());
            step();
        end
        rd_if.rd_ready = 1'b0;
        n_total++;
        if (empty !== 1'b1 || rd_if.rd_valid !== 1'b0)
            $display("FAIL drain_empty: empty=%b v=%b, want 1/0",
                     empty, rd_if.rd_valid);
        else n_pass++;
    endtask

    task automatic test_overrun();
        for (int i = 0; i < 16; i++) push_word(8'(8'h80 + i), 1'b1);
        push_word(8'h55, 1'b0);
        n_total++;
        if (overrun !== 1'b1 || count !== 5'd16)
            $display("FAIL overrun_set: ov=%b cnt=%0d, want 1/16", overrun, count);
        else n_pass++;
        rx_data = 8'h66;
        rx_ready = 1'b1;
        clr_overrun = 1'b1;
        step();
        rx_ready = 1'b0;
        clr_overrun = 1'b0;
        n_total++;
        if (overrun !== 1'b1 || count !== 5'd16)
            $display("FAIL overrun_set_wins: ov=%b cnt=%0d, want 1/16",
                     overrun, count);
        else n_pass++;
        clr_overrun = 1'b1;
        step();
        clr_overrun = 1'b0;
        n_total++;
        if (overrun !== 1'b0)
            $display("FAIL overrun_clear: ov=%b, want 0", overrun);
        else n_pass++;
    endtask

    task automatic test_full_rw();
        rx_data = 8'h77;
        rx_ready = 1'b1;
        rd_if.rd_ready = 1'b1;
        @(negedge sysclk);
        n_total++;
        if (rd_if.rd_data !== sb[0])
            $display("FAIL full_rw_head: d=%h, want %h", rd_if.rd_data, sb[0]);
        else n_pass++;
        void'(sb.pop_front());
        sb.push_back(8'h77);
        step();
        rx_ready = 1'b0;
        rd_if.rd_ready = 1'b0;
        n_total++;
        if (count !== 5'd16 || overrun !== 1'b0)
            $display("FAIL full_rw: cnt=%0d ov=%b, want 16/0", count, overrun);
        else n_pass++;
        rd_if.rd_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            @(negedge sysclk);
            n_total++;
            if (rd_if.rd_valid !== 1'b1 || rd_if.rd_data !== sb[0])
                $display("FAIL full_rw_drain_%0d: v=%b d=%h, want 1/%h",
                         i, rd_if.rd_valid, rd_if.rd_data, sb[0]);
            else n_pass++;
            void'(sb.pop_front());
            step();
        end
        rd_if.rd_ready = 1'b0;
        n_total++;
        if (empty !== 1'b1)
            $display("FAIL full_rw_empty: empty=%b, want 1", empty);
        else n_pass++;
    endtask

    task automatic test_interleave();
        int sent = 0;
        int got = 0;
        int max_cnt = 0;
        rd_if.rd_ready = 1'b1;
        for (int c = 0; c < 120; c++) begin
            if (c % 2 == 0 && sent < 40) begin
                rx_data = 8'((sent * 37 + 11) & 8'hFF);
                rx_ready = 1'b1;
                sb.push_back(rx_data);
                sent++;
            end else begin
                rx_ready = 1'b0;
            end
            @(negedge sysclk);
            if (int'(count) > max_cnt) max_cnt = int'(count);
            if (rd_if.rd_valid === 1'b1) begin
                n_total++;
                if (sb.size() == 0 || rd_if.rd_data !== sb[0])
                    $display("FAIL interleave_%0d: d=%h, want %h",
                             got, rd_if.rd_data, (sb.size() != 0) ? sb[0] : 8'hxx);
                else n_pass++;
                if (sb.size() != 0) void'(sb.pop_front());
                got++;
            end
            step();
        end
        rx_ready = 1'b0;
        rd_if.rd_ready = 1'b0;
        n_total++;
        if (got !== 40 || sb.size() !== 0 || max_cnt > 2)
            $display("FAIL interleave_total: got=%0d left=%0d max=%0d, want 40/0/<=2",
                     got, sb.size(), max_cnt);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 5; i++) push_word(8'(8'hC0 + i), 1'b1);
        rx_data = 8'h99;
        rx_ready = 1'b1;
        rst = 1'b1;
        step();
        rst = 1'b0;
        sb.delete();
        n_total++;
        if (count !== 5'd0 || rd_if.rd_valid !== 1'b0 || overrun !== 1'b0)
            $display("FAIL mid_reset: cnt=%0d v=%b ov=%b, want 0/0/0",
                     count, rd_if.rd_valid, overrun);
        else n_pass++;
        step();
        n_total++;
        if (count !== 5'd0)
            $display("FAIL mid_reset_level: cnt=%0d, want 0", count);
        else n_pass++;
        rx_ready = 1'b0;
        step();
        push_word(8'h3C, 1'b1);
        n_total++;
        if (count !== 5'd1 || rd_if.rd_data !== sb[0])
            $display("FAIL post_reset_write: cnt=%0d d=%h, want 1/%h",
                     count, rd_if.rd_data, sb[0]);
        else n_pass++;
    endtask

    initial begin
        rd_if.rd_ready = 1'b0;
        test_reset();
        test_fill_drain();
        test_overrun();
        test_full_rw();
        test_interleave();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
